// File: rtl/nv_clk_gate_power_ctrl.sv
//------------------------------------------------------------------------------
// Module  : nv_clk_gate_power_ctrl
// Brief   : Per-channel clock-gate enable sequencer with wake delay, idle
//           hysteresis, debug force-on and gated-cycle statistics.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nv_clk_gate_power_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 4,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_busy,
  input  logic [NUM_CH-1:0] force_on,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] clk_en,
  input  logic [SEL_W-1:0]  stat_sel,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_cnt
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int C_MAX_CYC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
  localparam int C_TMR_W   = $clog2(C_MAX_CYC + 1);

  localparam logic [C_TMR_W-1:0] C_WAKE_LD = C_TMR_W'(WAKE_CYC);
  localparam logic [C_TMR_W-1:0] C_IDLE_LD = C_TMR_W'(IDLE_CYC);
  localparam logic [C_TMR_W-1:0] C_TMR_ONE = C_TMR_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_MAX = {CNT_W{1'b1}};

  state_t             r_state     [NUM_CH];
  state_t             w_state_nxt [NUM_CH];
  logic [C_TMR_W-1:0] r_tmr       [NUM_CH];
  logic [C_TMR_W-1:0] w_tmr_nxt   [NUM_CH];
  logic [CNT_W-1:0]   r_stat      [NUM_CH];
  logic [NUM_CH-1:0]  w_en_nxt;
  logic [NUM_CH-1:0]  w_ack_nxt;
  logic [CNT_W-1:0]   w_sel_cnt;

  // Next-state and next-output logic for every channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_tmr_nxt[i]   = r_tmr[i];
      case (r_state[i])
        ST_OFF: begin
          if (ch_req[i]) begin
            w_state_nxt[i] = ST_WAKE;
            w_tmr_nxt[i]   = C_WAKE_LD;
          end
        end
        ST_WAKE: begin
          // A withdrawn request skips ack but still keeps the clock for hysteresis.
          if (!ch_req[i]) begin
            w_state_nxt[i] = ST_HOLD;
            w_tmr_nxt[i]   = C_IDLE_LD;
          end else if (r_tmr[i] <= C_TMR_ONE) begin
            w_state_nxt[i] = ST_ON;
            w_tmr_nxt[i]   = '0;
          end else begin
            w_tmr_nxt[i] = r_tmr[i] - C_TMR_ONE;
          end
        end
        ST_ON: begin
          if (!ch_req[i] && !ch_busy[i]) begin
            w_state_nxt[i] = ST_HOLD;
            w_tmr_nxt[i]   = C_IDLE_LD;
          end
        end
        ST_HOLD: begin
          if (ch_req[i]) begin
            w_state_nxt[i] = ST_ON;
            w_tmr_nxt[i]   = '0;
          end else if (ch_busy[i]) begin
            w_tmr_nxt[i] = C_IDLE_LD;
          end else if (r_tmr[i] <= C_TMR_ONE) begin
            w_state_nxt[i] = ST_OFF;
            w_tmr_nxt[i]   = '0;
          end else begin
            w_tmr_nxt[i] = r_tmr[i] - C_TMR_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_OFF;
          w_tmr_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_en_nxt  = '0;
    w_ack_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_en_nxt[i]  = (w_state_nxt[i] != ST_OFF) | force_on[i];
      w_ack_nxt[i] = (w_state_nxt[i] == ST_ON);
    end
  end

  // Out-of-range selects match no channel and therefore read back zero.
  always_comb begin
    w_sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (stat_sel == SEL_W'(i)) begin
        w_sel_cnt = r_stat[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_OFF;
        r_tmr[i]   <= '0;
        r_stat[i]  <= '0;
      end
      clk_en   <= '0;
      ch_ack   <= '0;
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_tmr[i]   <= w_tmr_nxt[i];
        // Clear has priority; otherwise count gated cycles and saturate.
        if (stat_clr && (stat_sel == SEL_W'(i))) begin
          r_stat[i] <= '0;
        end else if (!clk_en[i] && (r_stat[i] != C_CNT_MAX)) begin
          r_stat[i] <= r_stat[i] + 1'b1;
        end
      end
      clk_en   <= w_en_nxt;
      ch_ack   <= w_ack_nxt;
      stat_cnt <= w_sel_cnt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nv_clk_gate_power_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_nv_clk_gate_power_ctrl
// Brief   : Directed self-checking bench for nv_clk_gate_power_ctrl.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nv_clk_gate_power_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] ch_req;
  logic [1:0] ch_busy;
  logic [1:0] force_on;
  logic [1:0] ch_ack;
  logic [1:0] clk_en;
  logic [0:0] stat_sel;
  logic       stat_clr;
  logic [7:0] stat_cnt;

  int tests;
  int fails;

  nv_clk_gate_power_ctrl #(
    .NUM_CH  (2),
    .WAKE_CYC(2),
    .IDLE_CYC(4),
    .CNT_W   (8),
    .SEL_W   (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ch_req  (ch_req),
    .ch_busy (ch_busy),
    .force_on(force_on),
    .ch_ack  (ch_ack),
    .clk_en  (clk_en),
    .stat_sel(stat_sel),
    .stat_clr(stat_clr),
    .stat_cnt(stat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_en_ack(input string name, input logic [1:0] exp_en, input logic [1:0] exp_ack);
    tests++;
    if (clk_en !== exp_en) begin
      fails++;
      $display("FAIL %s clk_en: got %b expected %b (t=%0t)", name, clk_en, exp_en, $time);
    end
    tests++;
    if (ch_ack !== exp_ack) begin
      fails++;
      $display("FAIL %s ch_ack: got %b expected %b (t=%0t)", name, ch_ack, exp_ack, $time);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [7:0] exp_cnt);
    tests++;
    if (stat_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL %s stat_cnt: got %0d expected %0d (t=%0t)", name, stat_cnt, exp_cnt, $time);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ch_req   = 2'b11;
    ch_busy  = 2'b00;
    force_on = 2'b00;
    stat_sel = 1'b0;
    stat_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_en_ack("reset", 2'b00, 2'b00);
      chk_cnt("reset", 8'd0);
    end
    ch_req = 2'b00;
    reset  = 1'b0;
    tick();
    chk_en_ack("reset_release", 2'b00, 2'b00);
  endtask

  task automatic test_wake();
    ch_req = 2'b01;
    tick();
    chk_en_ack("wake_e0", 2'b01, 2'b00);
    tick();
    chk_en_ack("wake_e1", 2'b01, 2'b00);
    tick();
    chk_en_ack("wake_e2", 2'b01, 2'b01);
    tick();
    chk_en_ack("wake_e3", 2'b01, 2'b01);
  endtask

  task automatic test_idle();
    ch_req = 2'b00;
    tick();
    chk_en_ack("idle_e0", 2'b01, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_en_ack("idle_hold", 2'b01, 2'b00);
    end
    tick();
    chk_en_ack("idle_off", 2'b00, 2'b00);
  endtask

  task automatic test_rerequest();
    ch_req = 2'b01;
    repeat (3) tick();
    chk_en_ack("rereq_on", 2'b01, 2'b01);
    ch_req = 2'b00;
    tick();
    chk_en_ack("rereq_hold", 2'b01, 2'b00);
    tick();
    ch_req = 2'b01;
    tick();
    chk_en_ack("rereq_reack", 2'b01, 2'b01);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_en_ack("rereq_stay", 2'b01, 2'b01);
    end
  endtask

  task automatic test_busy();
    ch_req  = 2'b00;
    ch_busy = 2'b01;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_en_ack("busy_on", 2'b01, 2'b01);
    end
    ch_busy = 2'b00;
    tick();
    chk_en_ack("busy_fall", 2'b01, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_en_ack("busy_hyst", 2'b01, 2'b00);
    end
    tick();
    chk_en_ack("busy_off", 2'b00, 2'b00);
  endtask

  // Busy seen during HOLD restarts the full idle countdown.
  task automatic test_hold_reload();
    ch_req = 2'b01;
    repeat (3) tick();
    ch_req = 2'b00;
    tick();
    tick();
    ch_busy = 2'b01;
    tick();
    ch_busy = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_en_ack("reload_hold", 2'b01, 2'b00);
    end
    tick();
    chk_en_ack("reload_off", 2'b00, 2'b00);
  endtask

  task automatic test_force();
    force_on = 2'b10;
    stat_sel = 1'b1;
    stat_clr = 1'b1;
    tick();
    chk_en_ack("force_on", 2'b10, 2'b00);
    stat_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_en_ack("force_hold", 2'b10, 2'b00);
      chk_cnt("force_nocount", 8'd0);
    end
    force_on = 2'b00;
    tick();
    chk_en_ack("force_rel", 2'b00, 2'b00);
    tick();
    chk_cnt("force_rel_c0", 8'd0);
    tick();
    chk_cnt("force_rel_c1", 8'd1);
    tick();
    chk_cnt("force_rel_c2", 8'd2);
  endtask

  task automatic test_stats();
    stat_sel = 1'b0;
    repeat (300) tick();
    chk_cnt("stat_sat", 8'hFF);
    stat_clr = 1'b1;
    tick();
    chk_cnt("stat_clr_e0", 8'hFF);
    stat_clr = 1'b0;
    tick();
    chk_cnt("stat_clr_e1", 8'd0);
    tick();
    chk_cnt("stat_clr_e2", 8'd1);
    tick();
    chk_cnt("stat_clr_e3", 8'd2);
  endtask

  task automatic test_back_to_back();
    ch_req = 2'b11;
    repeat (3) tick();
    chk_en_ack("b2b_both_on", 2'b11, 2'b11);
    reset = 1'b1;
    tick();
    chk_en_ack("midrst", 2'b00, 2'b00);
    chk_cnt("midrst", 8'd0);
    reset = 1'b0;
    tick();
    chk_en_ack("midrst_wake0", 2'b11, 2'b00);
    tick();
    chk_en_ack("midrst_wake1", 2'b11, 2'b00);
    tick();
    chk_en_ack("midrst_ack", 2'b11, 2'b11);
    ch_req = 2'b10;
    tick();
    chk_en_ack("indep_drop0", 2'b11, 2'b10);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_wake();
    test_idle();
    test_rerequest();
    test_busy();
    test_hold_reload();
    test_force();
    test_stats();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
